// File: rtl/add64_serial_pkg.sv
// Shared constants for the nibble-serial 64-bit adder: FSM states and slice geometry.
package add64_serial_pkg;

    localparam int OP_W       = 64;
    localparam int SLICE_W    = 4;
    localparam int NUM_SLICES = OP_W / SLICE_W;
    localparam int LAST_IDX   = NUM_SLICES - 1;
    localparam int K_W        = $clog2(NUM_SLICES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add64_serial_add4.sv
// Combinational 4-bit ripple-carry slice, reused by the serial adder every RUN cycle.
module add4
    import add64_serial_pkg::*;
(
    input  logic [SLICE_W-1:0] a4,
    input  logic [SLICE_W-1:0] b4,
    input  logic               ci,
    output logic [SLICE_W-1:0] s4,
    output logic               co
);

    logic [SLICE_W:0] c;

    always_comb begin
        c    = '0;
        s4   = '0;
        c[0] = ci;
        for (int i = 0; i < SLICE_W; i++) begin
            s4[i]  = a4[i] ^ b4[i] ^ c[i];
            c[i+1] = (a4[i] & b4[i]) | (c[i] & (a4[i] ^ b4[i]));
        end
        co = c[SLICE_W];
    end

endmodule

// File: rtl/add64_serial.sv
// 64-bit adder computing one 4-bit slice per clock (16 RUN cycles, then a 1-cycle DONE).
// Define ADD64_SERIAL_OVF_EN to add the registered signed-overflow output ovf.
module add64_serial
    import add64_serial_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  logic            cin,
    output logic            busy,
    output logic            done,
    output logic [OP_W-1:0] s,
    output logic            cout
`ifdef ADD64_SERIAL_OVF_EN
    ,
    output logic            ovf
`endif
);

    state_t             state;
    logic [K_W-1:0]     k;
    logic               carry;
    logic [OP_W-1:0]    a_r;
    logic [OP_W-1:0]    b_r;
    logic [SLICE_W-1:0] sl_a;
    logic [SLICE_W-1:0] sl_b;
    logic [SLICE_W-1:0] sl_s;
    logic               sl_co;

    assign sl_a = a_r[k*SLICE_W +: SLICE_W];
    assign sl_b = b_r[k*SLICE_W +: SLICE_W];

    add4 u_add4 (
        .a4 (sl_a),
        .b4 (sl_b),
        .ci (carry),
        .s4 (sl_s),
        .co (sl_co)
    );

`ifdef ADD64_SERIAL_OVF_EN
    // Carry into bit 63 is recovered from the top bit of the last slice.
    logic c_into_msb;
    assign c_into_msb = sl_a[SLICE_W-1] ^ sl_b[SLICE_W-1] ^ sl_s[SLICE_W-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
`ifdef ADD64_SERIAL_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= cin;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    s[k*SLICE_W +: SLICE_W] <= sl_s;
                    carry <= sl_co;
                    k     <= k + 1'b1;
                    if (k == K_W'(LAST_IDX)) begin
                        cout  <= sl_co;
`ifdef ADD64_SERIAL_OVF_EN
                        ovf   <= sl_co ^ c_into_msb;
`endif
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add64_serial.sv
// Self-checking bench for add64_serial: directed vector table, random operands against
// a plain-arithmetic reference, plus mid-run start, reset abort and back-to-back sequences.
module tb_add64_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [63:0] s;
    logic        cout;
`ifdef ADD64_SERIAL_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    add64_serial dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
`ifdef ADD64_SERIAL_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] es;
        logic        ecout;
        logic        eovf;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Unsigned 65-bit sum and signed overflow from the arithmetic definition.
    function automatic logic [64:0] ref_sum(input logic [63:0] x, input logic [63:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + 65'(c);
    endfunction

    function automatic logic ref_ovf(input logic [63:0] x, input logic [63:0] y, input logic c);
        logic signed [65:0] sx;
        sx = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y}) + $signed({65'd0, c});
        return (sx > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (sx < -66'sh0_8000_0000_0000_0000);
    endfunction

    task automatic check_result(input string name, input logic [63:0] es, input logic ec, input logic eo);
        check({name, "_s"}, 128'(s), 128'(es));
        check({name, "_cout"}, 128'(cout), 128'(ec));
`ifdef ADD64_SERIAL_OVF_EN
        check({name, "_ovf"}, 128'(ovf), 128'(eo));
`else
        if (eo === 1'bx) $display("note: unexpected X in ovf expectation for %s", name);
`endif
    endtask

    // Present operands and hold start across one rising edge; leaves us at edge+1.
    task automatic accept(input logic [63:0] x, input logic [63:0] y, input logic c, input bit hold);
        a = x; b = y; cin = c; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        check("busy_after_accept", 128'(busy), 128'd1);
    endtask

    // Count edges until done; optionally scramble inputs and inject a start mid-run.
    task automatic wait_done(input bit scramble, input int inject_at, output int cyc);
        bit busy_ok = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                cyc = i;
                break;
            end
            if (scramble) begin
                a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom);
            end
            if (inject_at != 0 && i == inject_at) start = 1'b1;
            if (inject_at != 0 && i == inject_at + 1) start = 1'b0;
        end
        check("busy_held_until_done", 128'(busy_ok), 128'd1);
        check("done_latency", 128'(cyc), 128'd16);
    endtask

    task automatic full_op(input string name, input logic [63:0] x, input logic [63:0] y,
                           input logic c, input logic [63:0] es, input logic ec, input logic eo);
        int cyc;
        accept(x, y, c, 1'b0);
        wait_done(1'b1, 0, cyc);
        check_result(name, es, ec, eo);
        @(posedge clk); #1;
        check({name, "_done_pulse"}, 128'(done), 128'd0);
        check({name, "_idle_busy"}, 128'(busy), 128'd0);
    endtask

    initial begin
        vec_t        vt[7];
        logic [64:0] r;
        logic [63:0] ra, rb;
        logic        rc;
        int          cyc;
        bit          saw_done;
        logic [63:0] bb_a[4];
        logic [63:0] bb_b[4];
        logic        bb_c[4];

        vt[0] = '{64'h1, 64'h1, 1'b0, 64'h2, 1'b0, 1'b0};
        vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
        vt[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vt[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
        vt[4] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0};
        vt[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vt[6] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b1; a = '1; b = '1; cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_s", 128'(s), 128'd0);
        check("rst_cout", 128'(cout), 128'd0);
`ifdef ADD64_SERIAL_OVF_EN
        check("rst_ovf", 128'(ovf), 128'd0);
`endif
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++)
            full_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin, vt[i].es, vt[i].ecout, vt[i].eovf);

        // Result holds in IDLE while inputs wander.
        for (int i = 0; i < 5; i++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        check("idle_hold_s", 128'(s), 128'(vt[6].es));
        check("idle_hold_busy", 128'(busy), 128'd0);

        for (int i = 0; i < 20; i++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = 1'($urandom);
            if (i == 0) rb = ~ra;
            r = ref_sum(ra, rb, rc);
            full_op($sformatf("rand%0d", i), ra, rb, rc, r[63:0], r[64], ref_ovf(ra, rb, rc));
        end

        // Start pulsed mid-run with other operands must be ignored.
        ra = 64'h1234_5678_9ABC_DEF0; rb = 64'h0FED_CBA9_8765_4321; rc = 1'b1;
        accept(ra, rb, rc, 1'b0);
        wait_done(1'b1, 4, cyc);
        r = ref_sum(ra, rb, rc);
        check_result("midstart", r[63:0], r[64], ref_ovf(ra, rb, rc));
        @(posedge clk); #1;
        check("midstart_idle_busy", 128'(busy), 128'd0);
        @(posedge clk); #1;
        check("midstart_no_requeue", 128'(busy), 128'd0);

        // Reset abort on the 8th RUN edge.
        accept(64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 1'b1, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_s", 128'(s), 128'd0);
        check("abort_cout", 128'(cout), 128'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("abort_no_done", 128'(saw_done), 128'd0);
        check("abort_s_held", 128'(s), 128'd0);
        full_op("after_abort", 64'h5, 64'hA, 1'b0, 64'hF, 1'b0, 1'b0);

        // Reset wins over start on the same edge.
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("rst_over_start", 128'(busy), 128'd0);

        // Back-to-back with start held: 18-cycle period, each result correct.
        for (int n = 0; n < 4; n++) begin
            bb_a[n] = {$urandom, $urandom}; bb_b[n] = {$urandom, $urandom}; bb_c[n] = 1'($urandom);
        end
        accept(bb_a[0], bb_b[0], bb_c[0], 1'b1);
        for (int n = 0; n < 4; n++) begin
            wait_done(1'b1, 0, cyc);
            r = ref_sum(bb_a[n], bb_b[n], bb_c[n]);
            check_result($sformatf("b2b%0d", n), r[63:0], r[64], ref_ovf(bb_a[n], bb_b[n], bb_c[n]));
            if (n < 3) begin
                a = bb_a[n+1]; b = bb_b[n+1]; cin = bb_c[n+1];
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            check("b2b_idle_gap_busy", 128'(busy), 128'd0);
            check("b2b_idle_gap_done", 128'(done), 128'd0);
            @(posedge clk); #1;
            check("b2b_reaccept", 128'(busy), 128'(n < 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/add64_serial.md
ADD64_SERIAL -- requirements
Module: add64_serial

Interface
REQ-001 Parameters: none; operand width fixed at 64 bits, slice width fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  64  augend; captured on accepted start.
REQ-006 b  input  64  addend; captured on accepted start.
REQ-007 cin  input  1  carry-in to bit 0; captured on accepted start.
REQ-008 busy  output  1  high in RUN and DONE states.
REQ-009 done  output  1  one-cycle pulse; s/cout valid.
REQ-010 s  output  64  sum, registered.
REQ-011 cout  output  1  carry out of bit 63, registered.

Function
REQ-012 States SHALL be IDLE, RUN, DONE; encoding internal.
REQ-013 IDLE: start=1 at an edge -> latch a, b, cin; nibble index k=0; carry register=cin; go RUN.
REQ-014 IDLE: start=0 -> stay IDLE; s/cout hold last values.
REQ-015 RUN: each edge computes one 4-bit slice: s[4k+3:4k] = a[4k+3:4k] + b[4k+3:4k] + carry; carry updated with slice carry-out; k increments.
REQ-016 RUN at k=15: write top slice, cout = slice carry-out, go DONE.
REQ-017 Latency: exactly 16 RUN edges; done high during the 17th cycle after the accepting edge.
REQ-018 DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
REQ-019 start while busy (RUN or DONE) SHALL be ignored; operands not re-latched, no queuing.
REQ-020 Result: {cout, s} SHALL equal a + b + cin modulo 2^65; unsigned arithmetic.
REQ-021 s and cout SHALL change only in RUN; held from DONE until the next accepted start.
REQ-022 Input changes on a/b/cin after acceptance SHALL not affect the result.
REQ-023 Wrap-around: k is 4 bits; reaching k=15 ends RUN, never wraps into a 17th slice.

Reset
REQ-024 rst=1 at an edge -> state IDLE, k=0, carry=0, s=0, cout=0, done=0, busy=0.
REQ-025 rst overrides start in the same cycle; start ignored.
REQ-026 rst during RUN or DONE SHALL abort; partial sum discarded (s=0); no done pulse.

Configuration
REQ-027 Macro ADD64_SERIAL_OVF_EN: when defined, output ovf (1 bit) SHALL be added, = signed two's-complement overflow of the 64-bit sum (carry into bit 63 XOR cout), registered with cout, reset 0.
REQ-028 Without ADD64_SERIAL_OVF_EN: no ovf port; behaviour otherwise identical.

Structure
REQ-029 Shared package: state encoding constants (IDLE/RUN/DONE), slice width 4, slice count 16, last index 15.
REQ-030 One sub-module: add4, a combinational 4-bit ripple-carry adder slice (a4, b4, ci -> s4, co), instantiated once and reused every RUN cycle.

Verification
REQ-031 a=0x0000_0000_0000_0001, b=0x0000_0000_0000_0001, cin=0 -> after 17 cycles done=1, s=0x...0002, cout=0.
REQ-032 a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> s=0, cout=1 (carry ripples all 16 slices); ovf=0 when enabled.
REQ-033 a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> s=0x8000_0000_0000_0000, cout=0, ovf=1 when enabled.
REQ-034 start pulsed again at cycle 5 of a RUN with different operands -> ignored; first result delivered; busy stays 1 through DONE.
REQ-035 rst asserted at RUN cycle 8 -> next cycle IDLE, s=0, cout=0, no done pulse; fresh start afterwards gives correct sum.
REQ-036 Back-to-back: start held high continuously -> new operation accepted in the IDLE cycle following each DONE; 18-cycle period, every result correct.
